sub_bytes_unit: RTL and testbench

- AES SubBytes stage with an internal, run-time-loadable 256x8 S-box memory that has four read ports.
- A sequencer substitutes a 16-byte state, four bytes per cycle over four cycles, and pulses done when the result is ready.
- The S-box is loaded through a byte-wide write port before use.
- The block sits between AddRoundKey and ShiftRows in the 128-bit AES encryption datapath.

---
 rtl/sub_bytes_unit_if.sv | 35 +++
 rtl/sub_bytes_unit.sv | 163 ++++++++++++++++
 tb/tb_sub_bytes_unit.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sub_bytes_unit_if.sv
// Bus bundle for the SubBytes unit: S-box load port, start request,
// the 16 input state bytes and the 16 registered substituted bytes.
interface sub_bytes_unit_if;
  logic       wr_en;
  logic [7:0] addr;
  logic [7:0] in;
  logic       en;

  logic [7:0] b0,  b1,  b2,  b3,  b4,  b5,  b6,  b7;
  logic [7:0] b8,  b9,  b10, b11, b12, b13, b14, b15;

  logic [7:0] s0,  s1,  s2,  s3,  s4,  s5,  s6,  s7;
  logic [7:0] s8,  s9,  s10, s11, s12, s13, s14, s15;

  logic       busy;
  logic       done;

  modport master (
    output wr_en, addr, in, en,
    output b0, b1, b2, b3, b4, b5, b6, b7,
    output b8, b9, b10, b11, b12, b13, b14, b15,
    input  s0, s1, s2, s3, s4, s5, s6, s7,
    input  s8, s9, s10, s11, s12, s13, s14, s15,
    input  busy, done
  );

  modport slave (
    input  wr_en, addr, in, en,
    input  b0, b1, b2, b3, b4, b5, b6, b7,
    input  b8, b9, b10, b11, b12, b13, b14, b15,
    output s0, s1, s2, s3, s4, s5, s6, s7,
    output s8, s9, s10, s11, s12, s13, s14, s15,
    output busy, done
  );
endinterface

// File: rtl/sub_bytes_unit.sv
// AES SubBytes stage: run-time loadable 256x8 S-box with four synchronous
// read ports, substituting a latched 16-byte state four bytes per cycle.
module sub_bytes_unit (
  input  logic            clk,
  input  logic            rst,
  sub_bytes_unit_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    RD1,
    RD2,
    RD3,
    CAP,
    DONE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] mem       [256];
  logic [7:0] b_in      [16];
  logic [7:0] lat_q     [16];
  logic [7:0] lat_d     [16];
  logic [7:0] s_q       [16];
  logic [7:0] s_d       [16];
  logic       done_q, done_d;
  logic [1:0] rd_grp;
  logic [1:0] cap_grp;
  logic       cap_en;
  logic [7:0] rd_addr   [4];
  logic [7:0] rd_data_q [4];

  assign b_in[0]  = bus.b0;
  assign b_in[1]  = bus.b1;
  assign b_in[2]  = bus.b2;
  assign b_in[3]  = bus.b3;
  assign b_in[4]  = bus.b4;
  assign b_in[5]  = bus.b5;
  assign b_in[6]  = bus.b6;
  assign b_in[7]  = bus.b7;
  assign b_in[8]  = bus.b8;
  assign b_in[9]  = bus.b9;
  assign b_in[10] = bus.b10;
  assign b_in[11] = bus.b11;
  assign b_in[12] = bus.b12;
  assign b_in[13] = bus.b13;
  assign b_in[14] = bus.b14;
  assign b_in[15] = bus.b15;

  // Contents are deliberately not reset; a same-edge read returns the old word.
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      mem[bus.addr] <= bus.in;
    end
    for (int i = 0; i < 4; i++) begin
      rd_data_q[i] <= mem[rd_addr[i]];
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rd_addr[i] = lat_q[{rd_grp, 2'(i)}];
    end
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    s_d     = s_q;
    done_d  = 1'b0;
    rd_grp  = 2'd0;
    cap_grp = 2'd0;
    cap_en  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.en && !bus.wr_en) begin
          lat_d   = b_in;
          state_d = RD0;
        end
      end
      RD0: begin
        rd_grp  = 2'd0;
        state_d = RD1;
      end
      RD1: begin
        rd_grp  = 2'd1;
        cap_grp = 2'd0;
        cap_en  = 1'b1;
        state_d = RD2;
      end
      RD2: begin
        rd_grp  = 2'd2;
        cap_grp = 2'd1;
        cap_en  = 1'b1;
        state_d = RD3;
      end
      RD3: begin
        rd_grp  = 2'd3;
        cap_grp = 2'd2;
        cap_en  = 1'b1;
        state_d = CAP;
      end
      CAP: begin
        cap_grp = 2'd3;
        cap_en  = 1'b1;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Read data always lags the address by one cycle, so each state captures
    // the group whose addresses were presented in the previous state.
    if (cap_en) begin
      for (int i = 0; i < 4; i++) begin
        s_d[{cap_grp, 2'(i)}] = rd_data_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        lat_q[i] <= 8'h00;
        s_q[i]   <= 8'h00;
      end
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      lat_q   <= lat_d;
      s_q     <= s_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;

  assign bus.s0  = s_q[0];
  assign bus.s1  = s_q[1];
  assign bus.s2  = s_q[2];
  assign bus.s3  = s_q[3];
  assign bus.s4  = s_q[4];
  assign bus.s5  = s_q[5];
  assign bus.s6  = s_q[6];
  assign bus.s7  = s_q[7];
  assign bus.s8  = s_q[8];
  assign bus.s9  = s_q[9];
  assign bus.s10 = s_q[10];
  assign bus.s11 = s_q[11];
  assign bus.s12 = s_q[12];
  assign bus.s13 = s_q[13];
  assign bus.s14 = s_q[14];
  assign bus.s15 = s_q[15];

endmodule

// File: tb/tb_sub_bytes_unit.sv
// Self-checking bench for sub_bytes_unit; the reference S-box is derived from
// GF(2^8) inversion plus the AES affine map, and results come from a table lookup.
module tb_sub_bytes_unit;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       en;
  logic [7:0] b_drv [16];
  logic [7:0] s_obs [16];
  logic       busy;
  logic       done;

  int         errors = 0;
  int         checks = 0;

  logic [7:0] sbox_model [256];
  logic [7:0] aes_tbl    [256];
  logic [7:0] rnd_tbl    [256];

  sub_bytes_unit_if bus ();

  sub_bytes_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.wr_en = wr_en;
  assign bus.addr  = addr;
  assign bus.in    = wdata;
  assign bus.en    = en;
  assign bus.b0  = b_drv[0];
  assign bus.b1  = b_drv[1];
  assign bus.b2  = b_drv[2];
  assign bus.b3  = b_drv[3];
  assign bus.b4  = b_drv[4];
  assign bus.b5  = b_drv[5];
  assign bus.b6  = b_drv[6];
  assign bus.b7  = b_drv[7];
  assign bus.b8  = b_drv[8];
  assign bus.b9  = b_drv[9];
  assign bus.b10 = b_drv[10];
  assign bus.b11 = b_drv[11];
  assign bus.b12 = b_drv[12];
  assign bus.b13 = b_drv[13];
  assign bus.b14 = b_drv[14];
  assign bus.b15 = b_drv[15];
  assign s_obs[0]  = bus.s0;
  assign s_obs[1]  = bus.s1;
  assign s_obs[2]  = bus.s2;
  assign s_obs[3]  = bus.s3;
  assign s_obs[4]  = bus.s4;
  assign s_obs[5]  = bus.s5;
  assign s_obs[6]  = bus.s6;
  assign s_obs[7]  = bus.s7;
  assign s_obs[8]  = bus.s8;
  assign s_obs[9]  = bus.s9;
  assign s_obs[10] = bus.s10;
  assign s_obs[11] = bus.s11;
  assign s_obs[12] = bus.s12;
  assign s_obs[13] = bus.s13;
  assign s_obs[14] = bus.s14;
  assign s_obs[15] = bus.s15;
  assign busy = bus.busy;
  assign done = bus.done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] aes_sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    if (x != 8'h00) begin
      for (int y = 1; y < 256; y++) begin
        if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      end
    end
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] bytes [16], input logic en_val);
    b_drv = bytes;
    en    = en_val;
  endtask

  task automatic checkAllZero(input string tag);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("%s_s%0d", tag, i), s_obs[i], 0);
    end
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_busy"}, busy, 0);
  endtask

  task automatic loadTable(input logic [7:0] tbl [256]);
    en = 1'b0;
    for (int a = 0; a < 256; a++) begin
      wr_en = 1'b1;
      addr  = 8'(a);
      wdata = tbl[a];
      @(negedge clk);
    end
    wr_en = 1'b0;
    sbox_model = tbl;
  endtask

  // Must be entered right after a negedge with the unit idle.
  task automatic startAndCheck(input logic [7:0] bytes [16], input bit change_mid,
                               input bit write_mid, input logic [7:0] wval, input string tag);
    logic [7:0] exp_s [16];
    logic [7:0] ff_bytes [16];
    for (int i = 0; i < 16; i++) begin
      exp_s[i]    = sbox_model[bytes[i]];
      ff_bytes[i] = 8'hff;
    end
    applyStimulus(bytes, 1'b1);
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    checkOutput({tag, "_busy_e0"}, busy, 1);
    checkOutput({tag, "_done_e0"}, done, 0);
    if (change_mid) applyStimulus(ff_bytes, 1'b0);
    if (write_mid) begin
      wr_en = 1'b1;
      addr  = bytes[15];
      wdata = wval;
      sbox_model[bytes[15]] = wval;
      for (int i = 4; i < 16; i++) begin
        if (bytes[i] == bytes[15]) exp_s[i] = wval;
      end
    end
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      @(negedge clk);
      wr_en = 1'b0;
      if (e == 2) begin
        for (int i = 0; i < 4; i++) begin
          checkOutput($sformatf("%s_grp0_s%0d", tag, i), s_obs[i], exp_s[i]);
        end
      end
      checkOutput($sformatf("%s_done_e%0d", tag, e), done, (e == 5));
      if (e == 5) begin
        for (int i = 0; i < 16; i++) begin
          checkOutput($sformatf("%s_s%0d", tag, i), s_obs[i], exp_s[i]);
        end
      end
      if (e == 6) checkOutput({tag, "_busy_e6"}, busy, 0);
    end
  endtask

  initial begin
    logic [7:0] bytes [16];
    logic [7:0] spec1 [16];
    logic [7:0] exp_s [16];
    int         pulse_cyc [$];

    spec1 = '{8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
              8'h30, 8'h01, 8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59};
    for (int a = 0; a < 256; a++) aes_tbl[a] = aes_sbox(8'(a));

    rst   = 1'b0;
    wr_en = 1'b0;
    addr  = 8'h00;
    wdata = 8'h00;
    en    = 1'b0;
    for (int i = 0; i < 16; i++) b_drv[i] = 8'h00;

    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] loading standard AES S-box");
    loadTable(aes_tbl);

    for (int i = 0; i < 16; i++) bytes[i] = (i < 10) ? 8'(i) : 8'(i + 6);
    startAndCheck(bytes, 1'b0, 1'b0, 8'h00, "aes_vec");
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("aes_const_s%0d", i), s_obs[i], spec1[i]);
    end

    #2;
    rst = 1'b0;
    #1;
    checkAllZero("async_rst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) bytes[i] = 8'($urandom());
    wr_en = 1'b1;
    addr  = 8'h00;
    wdata = sbox_model[0];
    applyStimulus(bytes, 1'b1);
    repeat (2) begin
      @(negedge clk);
      checkOutput("blocked_busy", busy, 0);
    end
    wr_en = 1'b0;
    startAndCheck(bytes, 1'b0, 1'b0, 8'h00, "unblocked");

    for (int i = 0; i < 16; i++) bytes[i] = 8'hff;
    startAndCheck(bytes, 1'b0, 1'b0, 8'h00, "all_ff");
    checkOutput("all_ff_s0_is_16", s_obs[0], 8'h16);
    for (int i = 0; i < 16; i++) bytes[i] = 8'h00;
    startAndCheck(bytes, 1'b0, 1'b0, 8'h00, "all_00");
    checkOutput("all_00_s15_is_63", s_obs[15], 8'h63);

    for (int i = 0; i < 16; i++) bytes[i] = 8'($urandom_range(0, 254));
    startAndCheck(bytes, 1'b1, 1'b0, 8'h00, "in_change");

    for (int i = 0; i < 16; i++) bytes[i] = 8'(8'h40 + i);
    startAndCheck(bytes, 1'b0, 1'b1, 8'hA5, "mid_write");

    $display("[TB] loading random S-box contents");
    for (int a = 0; a < 256; a++) rnd_tbl[a] = 8'($urandom());
    loadTable(rnd_tbl);
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) bytes[i] = 8'($urandom());
      startAndCheck(bytes, 1'b0, 1'b0, 8'h00, $sformatf("rnd%0d", r));
    end

    for (int i = 0; i < 16; i++) bytes[i] = 8'($urandom());
    applyStimulus(bytes, 1'b1);
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkAllZero("mid_rst");
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checkOutput("mid_rst_no_done", done, 0);
      checkOutput("mid_rst_idle", busy, 0);
    end

    for (int i = 0; i < 16; i++) begin
      bytes[i] = 8'($urandom());
      exp_s[i] = sbox_model[bytes[i]];
    end
    applyStimulus(bytes, 1'b1);
    for (int cyc = 1; cyc <= 24; cyc++) begin
      @(negedge clk);
      if (done) begin
        pulse_cyc.push_back(cyc);
        for (int i = 0; i < 16; i++) begin
          checkOutput($sformatf("b2b_c%0d_s%0d", cyc, i), s_obs[i], exp_s[i]);
        end
      end
    end
    en = 1'b0;
    checkOutput("b2b_pulse_count", pulse_cyc.size(), 3);
    if (pulse_cyc.size() > 0) checkOutput("b2b_first_pulse", pulse_cyc[0], 6);
    for (int k = 1; k < pulse_cyc.size(); k++) begin
      checkOutput($sformatf("b2b_spacing%0d", k), pulse_cyc[k] - pulse_cyc[k - 1], 7);
    end
    repeat (8) @(negedge clk);
    checkOutput("final_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
